// File: rtl/fwd_pkg.sv
// Shared types for operand forwarding: mux select codes, pipeline tracker entries and the producer test.
// Latency: none (types and a pure function only); backpressure: not applicable.
package fwd_pkg;

    localparam int RW_DEF = 4;

    typedef enum logic [2:0] {
        SEL_REGFILE = 3'd0,
        SEL_MEM_ALU = 3'd1,
        SEL_WB_ALU  = 3'd2,
        SEL_WB_LOAD = 3'd3,
        SEL_IMM     = 3'd4,
        SEL_PC      = 3'd5,
        SEL_ZERO    = 3'd6,
        SEL_RSVD    = 3'd7
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [RW_DEF-1:0] rd;
        logic              we;
        logic              load;
    } trk_entry_t;

    // Register 0 never produces a value, so it can never be a forwarding source.
    function automatic logic produces(input trk_entry_t e, input logic [RW_DEF-1:0] rs);
        return e.valid & e.we & (e.rd != '0) & (e.rd == rs);
    endfunction

endpackage

// File: rtl/operand_forward_ctrl_if.sv
// Decode-side inputs and EX-side select/stall outputs of the operand forwarding controller.
// Latency: wires only; backpressure: stall tells the front end to hold PC and IF/ID.
interface operand_forward_ctrl_if #(
    parameter int RW    = fwd_pkg::RW_DEF,
    parameter int CNT_W = 16
) ();
    import fwd_pkg::*;

    logic             en;
    logic             flush;
    logic             id_valid;
    logic [RW-1:0]    id_rs_a;
    logic [RW-1:0]    id_rs_b;
    logic             id_b_imm;
    logic [RW-1:0]    id_rd;
    logic             id_we;
    logic             id_is_load;
    fwd_sel_e         sel_a;
    fwd_sel_e         sel_b;
    logic             ex_valid;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output en, flush, id_valid, id_rs_a, id_rs_b, id_b_imm, id_rd, id_we, id_is_load,
        input  sel_a, sel_b, ex_valid, stall, stall_cnt
    );

    modport slave (
        input  en, flush, id_valid, id_rs_a, id_rs_b, id_b_imm, id_rd, id_we, id_is_load,
        output sel_a, sel_b, ex_valid, stall, stall_cnt
    );
endinterface

// File: rtl/src_forward_select.sv
// Picks the forwarding source for one operand from the EX/MEM/WB tracker; flags a load-use hazard.
// Latency: combinational; backpressure: load_hazard feeds the decode stall.
module src_forward_select
    import fwd_pkg::*;
(
    input  logic [RW_DEF-1:0] rs,
    input  logic              use_imm,
    input  trk_entry_t        ex_e,
    input  trk_entry_t        mem_e,
    input  trk_entry_t        wb_e,
    output fwd_sel_e          code,
    output logic              load_hazard
);

    // Checked youngest-first so the most recent writer of rs wins.
    always_comb begin
        code        = SEL_REGFILE;
        load_hazard = 1'b0;
        if (use_imm) begin
            code = SEL_IMM;
        end else if (rs == '0) begin
            code = SEL_ZERO;
        end else if (produces(ex_e, rs)) begin
            code        = SEL_MEM_ALU;
            load_hazard = ex_e.load;
        end else if (produces(mem_e, rs)) begin
            code = mem_e.load ? SEL_WB_LOAD : SEL_WB_ALU;
        end else if (produces(wb_e, rs)) begin
            // WB writes the regfile before the read, so the regfile value is already current.
            code = SEL_REGFILE;
        end
    end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Tracks EX/MEM/WB destinations, registers operand mux selects and raises a 1-cycle load-use stall.
// Latency: 1 cycle decode->sel/ex_valid, stall combinational; backpressure: stall holds decode and issues a bubble.
module operand_forward_ctrl
    import fwd_pkg::*;
#(
    parameter int RW    = RW_DEF,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    operand_forward_ctrl_if.slave bus
);

    trk_entry_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    fwd_sel_e         sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    fwd_sel_e code_a, code_b;
    logic     haz_a, haz_b;
    logic     stall;
    logic     issue_vld;

    src_forward_select u_sel_a (
        .rs          (bus.id_rs_a),
        .use_imm     (1'b0),
        .ex_e        (ex_q),
        .mem_e       (mem_q),
        .wb_e        (wb_q),
        .code        (code_a),
        .load_hazard (haz_a)
    );

    src_forward_select u_sel_b (
        .rs          (bus.id_rs_b),
        .use_imm     (bus.id_b_imm),
        .ex_e        (ex_q),
        .mem_e       (mem_q),
        .wb_e        (wb_q),
        .code        (code_b),
        .load_hazard (haz_b)
    );

    // A flushed instruction never stalls; it is squashed into a bubble instead.
    assign stall     = bus.en & bus.id_valid & ~bus.flush & (haz_a | haz_b);
    assign issue_vld = bus.id_valid & ~bus.flush;

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        ex_valid_d  = ex_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.en) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (stall || bus.flush) begin
                ex_d       = '0;
                sel_a_d    = SEL_ZERO;
                sel_b_d    = SEL_ZERO;
                ex_valid_d = 1'b0;
            end else begin
                ex_d       = '{valid: issue_vld, rd: bus.id_rd, we: bus.id_we, load: bus.id_is_load};
                sel_a_d    = code_a;
                sel_b_d    = code_b;
                ex_valid_d = issue_vld;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            sel_a_q     <= SEL_REGFILE;
            sel_b_q     <= SEL_REGFILE;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.sel_a     = sel_a_q;
    assign bus.sel_b     = sel_b_q;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Bench for operand_forward_ctrl: directed hazard scenarios plus randomized traffic against an issue-history model.
module tb_operand_forward_ctrl;

    localparam int TB_RW    = 4;
    localparam int TB_CNT_W = 5;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    operand_forward_ctrl_if #(.RW(TB_RW), .CNT_W(TB_CNT_W)) bus ();

    operand_forward_ctrl #(.RW(TB_RW), .CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: the last three issued instructions, youngest first (age 0 = EX).
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } instr_t;

    instr_t hist[3];
    int     m_sel_a = 0;
    int     m_sel_b = 0;
    bit     m_ex_valid = 0;
    int     m_cnt = 0;

    function automatic void src_code(input int rs, input bit imm, output int code, output bit haz);
        code = 0;
        haz  = 0;
        if (imm) begin
            code = 4;
            return;
        end
        if (rs == 0) begin
            code = 6;
            return;
        end
        for (int age = 0; age < 3; age++) begin
            if (hist[age].v && hist[age].we && hist[age].rd == rs) begin
                case (age)
                    0:       begin code = 1; haz = hist[age].ld; end
                    1:       code = hist[age].ld ? 3 : 2;
                    default: code = 0;
                endcase
                return;
            end
        end
    endfunction

    function automatic bit model_stall();
        int ca, cb;
        bit ha, hb;
        src_code(int'(bus.id_rs_a), 1'b0, ca, ha);
        src_code(int'(bus.id_rs_b), bus.id_b_imm, cb, hb);
        return bus.en && bus.id_valid && !bus.flush && (ha || hb);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin : model_update
        int ca, cb;
        bit ha, hb, st, fl;
        instr_t nw;
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i] <= '{0, 0, 0, 0};
            m_sel_a    <= 0;
            m_sel_b    <= 0;
            m_ex_valid <= 0;
            m_cnt      <= 0;
        end else if (bus.en) begin
            src_code(int'(bus.id_rs_a), 1'b0, ca, ha);
            src_code(int'(bus.id_rs_b), bus.id_b_imm, cb, hb);
            fl = bus.flush;
            st = bus.id_valid && !fl && (ha || hb);
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            if (st || fl) begin
                nw = '{0, 0, 0, 0};
                m_sel_a    <= 6;
                m_sel_b    <= 6;
                m_ex_valid <= 0;
            end else begin
                nw = '{bus.id_valid, int'(bus.id_rd), bus.id_we, bus.id_is_load};
                m_sel_a    <= ca;
                m_sel_b    <= cb;
                m_ex_valid <= bus.id_valid;
            end
            hist[0] <= nw;
            if (st && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("cyc_sel_a", bus.sel_a, m_sel_a);
        chk("cyc_sel_b", bus.sel_b, m_sel_b);
        chk("cyc_ex_valid", bus.ex_valid, m_ex_valid);
        chk("cyc_stall", bus.stall, model_stall());
        chk("cyc_stall_cnt", bus.stall_cnt, m_cnt);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int ra, input int rb, input bit imm,
                          input int rd, input bit we, input bit ld);
        bus.id_valid   = v;
        bus.id_rs_a    = ra[TB_RW-1:0];
        bus.id_rs_b    = rb[TB_RW-1:0];
        bus.id_b_imm   = imm;
        bus.id_rd      = rd[TB_RW-1:0];
        bus.id_we      = we;
        bus.id_is_load = ld;
    endtask

    task automatic nops(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (n) cyc();
    endtask

    initial begin
        bus.en    = 1'b1;
        bus.flush = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #3;
        chk("rst_sel_a", bus.sel_a, 0);
        chk("rst_sel_b", bus.sel_b, 0);
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_cnt", bus.stall_cnt, 0);
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        cyc();

        // ADD r3,r1,r2 ; ADD r4,r3,r3
        set_in(1, 1, 2, 0, 3, 1, 0);
        cyc();
        chk("add1_ex_valid", bus.ex_valid, 1);
        chk("add1_sel_a", bus.sel_a, 0);
        set_in(1, 3, 3, 0, 4, 1, 0);
        #1 chk("add2_stall", bus.stall, 0);
        cyc();
        chk("b2b_sel_a", bus.sel_a, 1);
        chk("b2b_sel_b", bus.sel_b, 1);
        nops(3);

        // ADD r5 ; NOP ; SUB r6,r5,r1
        set_in(1, 1, 2, 0, 5, 1, 0); cyc();
        nops(1);
        set_in(1, 5, 1, 0, 6, 1, 0); cyc();
        chk("gap1_sel_a", bus.sel_a, 2);
        chk("gap1_sel_b", bus.sel_b, 0);
        nops(3);

        // ADD r8 ; NOP ; NOP ; SUB r9,r8,r1
        set_in(1, 1, 2, 0, 8, 1, 0); cyc();
        nops(2);
        set_in(1, 8, 1, 0, 9, 1, 0); cyc();
        chk("gap2_sel_a", bus.sel_a, 0);
        nops(3);

        // LOAD r2 ; ADD r7,r2,imm
        set_in(1, 1, 0, 1, 2, 1, 1); cyc();
        set_in(1, 2, 0, 1, 7, 1, 0);
        #1 chk("lu_stall", bus.stall, 1);
        cyc();
        chk("lu_bubble_ex_valid", bus.ex_valid, 0);
        chk("lu_bubble_sel_a", bus.sel_a, 6);
        chk("lu_bubble_sel_b", bus.sel_b, 6);
        chk("lu_cnt", bus.stall_cnt, 1);
        chk("lu_stall_drop", bus.stall, 0);
        cyc();
        chk("lu_sel_a", bus.sel_a, 3);
        chk("lu_sel_b", bus.sel_b, 4);
        chk("lu_ex_valid", bus.ex_valid, 1);
        nops(3);

        // LOAD r0 ; ADD r9,r0,r0
        set_in(1, 1, 2, 0, 0, 1, 1); cyc();
        set_in(1, 0, 0, 0, 9, 1, 0);
        #1 chk("r0_stall", bus.stall, 0);
        cyc();
        chk("r0_sel_a", bus.sel_a, 6);
        chk("r0_sel_b", bus.sel_b, 6);
        nops(3);

        // en=0 and flush during a load-use stall
        set_in(1, 1, 0, 1, 10, 1, 1); cyc();
        set_in(1, 10, 10, 0, 11, 1, 0);
        #1 chk("en_stall_on", bus.stall, 1);
        bus.en = 1'b0;
        #1 chk("en0_stall", bus.stall, 0);
        cyc(); cyc();
        chk("en0_sel_a", bus.sel_a, 0);
        chk("en0_sel_b", bus.sel_b, 4);
        chk("en0_ex_valid", bus.ex_valid, 1);
        chk("en0_cnt", bus.stall_cnt, 1);
        bus.en = 1'b1;
        #1 chk("en1_stall", bus.stall, 1);
        bus.flush = 1'b1;
        #1 chk("flush_stall", bus.stall, 0);
        cyc();
        chk("flush_ex_valid", bus.ex_valid, 0);
        chk("flush_sel_a", bus.sel_a, 6);
        chk("flush_cnt", bus.stall_cnt, 1);
        bus.flush = 1'b0;
        nops(3);

        // Reset in the middle of a load-use stall
        set_in(1, 1, 0, 1, 12, 1, 1); cyc();
        set_in(1, 12, 3, 0, 13, 1, 0);
        #1 chk("mr_stall_on", bus.stall, 1);
        rst = 1'b1;
        #1;
        chk("mr_stall", bus.stall, 0);
        chk("mr_sel_a", bus.sel_a, 0);
        chk("mr_sel_b", bus.sel_b, 0);
        chk("mr_ex_valid", bus.ex_valid, 0);
        chk("mr_cnt", bus.stall_cnt, 0);
        #3 rst = 1'b0;
        cyc();
        chk("mr_reissue_ex_valid", bus.ex_valid, 1);
        chk("mr_reissue_sel_a", bus.sel_a, 0);
        chk("mr_reissue_cnt", bus.stall_cnt, 0);

        // Randomized traffic, small register space for frequent hazards
        repeat (3000) begin
            bus.en    = ($urandom_range(0, 9) != 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            set_in($urandom_range(0, 9) != 0,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   $urandom_range(0, 3) == 0,
                   int'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 9) < 3);
            cyc();
        end
        bus.en    = 1'b1;
        bus.flush = 1'b0;
        nops(2);
        chk("cnt_saturated", bus.stall_cnt, CNT_MAX);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
